// File: rtl/tpm_spi_host.sv
// TPM SPI host: shifts a 4-byte header out, handles TPM wait states, then moves
// 1..64 data bytes (SPI mode 0, MSB first) and reports done/timeout.
module tpm_spi_host #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_read,
  input  logic [5:0]  req_size,
  input  logic [23:0] req_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_take,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic        timeout,
  output logic        SPI_clk,
  output logic        SPI_cs_n,
  output logic        SPI_mosi,
  input  logic        SPI_miso
);

  localparam int unsigned DivW  = $clog2(CLK_DIV + 1);
  localparam int unsigned WaitW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  typedef enum logic [2:0] {StIdle, StHeader, StWait, StData, StFinish} state_e;

  state_e             state_q, state_d;
  logic [DivW-1:0]    div_q, div_d;
  logic               sclk_q, sclk_d;
  logic               cs_n_q, cs_n_d;
  logic [7:0]         sr_q, sr_d;
  logic [6:0]         rx_q, rx_d;
  logic [3:0]         bit_q, bit_d;
  logic [5:0]         byte_q, byte_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic               read_q, read_d;
  logic [5:0]         size_q, size_d;
  logic [23:0]        addr_q, addr_d;
  logic               to_pend_q, to_pend_d;
  logic [7:0]         rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;

  logic       active, tick, rise, fall, byte_end;
  logic       hdr_more, data_last, load_data;
  logic [7:0] hdr_next;

  assign active    = (state_q == StHeader) || (state_q == StWait) || (state_q == StData);
  assign tick      = active && (div_q == DivW'(CLK_DIV - 1));
  assign rise      = tick && !sclk_q;
  assign fall      = tick && sclk_q;
  // A byte ends on the falling edge that follows its 8th rising edge.
  assign byte_end  = fall && (bit_q == 4'd8);
  assign hdr_more  = (state_q == StHeader) && (byte_q != 6'd3);
  assign data_last = (state_q == StData) && (byte_q == size_q);
  // rx_q[0] holds the MISO bit sampled on the last rising edge of the byte.
  assign load_data = byte_end && !hdr_more && !data_last && ((state_q == StData) || rx_q[0]);
  assign hdr_next  = (byte_q[1:0] == 2'd0) ? addr_q[23:16] :
                     (byte_q[1:0] == 2'd1) ? addr_q[15:8]  : addr_q[7:0];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      div_q      <= '0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      sr_q       <= '0;
      rx_q       <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      wait_q     <= '0;
      read_q     <= 1'b0;
      size_q     <= '0;
      addr_q     <= '0;
      to_pend_q  <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      sr_q       <= sr_d;
      rx_q       <= rx_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      wait_q     <= wait_d;
      read_q     <= read_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      to_pend_q  <= to_pend_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    sr_d       = sr_q;
    rx_d       = rx_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    wait_d     = wait_q;
    read_d     = read_q;
    size_d     = size_q;
    addr_d     = addr_q;
    to_pend_d  = to_pend_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    timeout_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = StHeader;
          read_d  = req_read;
          size_d  = req_size;
          addr_d  = req_addr;
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
          sr_d    = {req_read, 1'b0, req_size};
          div_d   = '0;
          bit_d   = '0;
          byte_d  = '0;
          wait_d  = '0;
        end
      end
      StHeader, StWait, StData: begin
        div_d = tick ? '0 : div_q + DivW'(1);
        if (rise) begin
          sclk_d = 1'b1;
          rx_d   = {rx_q[5:0], SPI_miso};
          bit_d  = bit_q + 4'd1;
          if ((state_q == StData) && read_q && (bit_q == 4'd7)) begin
            rd_data_d  = {rx_q, SPI_miso};
            rd_valid_d = 1'b1;
          end
        end
        if (fall) begin
          sclk_d = 1'b0;
          sr_d   = {sr_q[6:0], 1'b0};
        end
        if (byte_end) begin
          bit_d = '0;
          if (hdr_more) begin
            byte_d = byte_q + 6'd1;
            sr_d   = hdr_next;
          end else if (data_last) begin
            state_d = StFinish;
            sr_d    = '0;
            div_d   = '0;
          end else if (load_data) begin
            state_d = StData;
            byte_d  = (state_q == StData) ? byte_q + 6'd1 : 6'd0;
            sr_d    = read_q ? 8'h00 : wr_data;
          end else if (wait_q < WaitW'(MAX_WAIT)) begin
            state_d = StWait;
            wait_d  = wait_q + WaitW'(1);
            sr_d    = '0;
          end else begin
            state_d   = StFinish;
            to_pend_d = 1'b1;
            sr_d      = '0;
            div_d     = '0;
          end
        end
      end
      StFinish: begin
        cs_n_d = 1'b1;
        div_d  = div_q + DivW'(1);
        if (div_q == DivW'(CLK_DIV)) begin
          state_d   = StIdle;
          div_d     = '0;
          done_d    = 1'b1;
          timeout_d = to_pend_q;
          to_pend_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready = (state_q == StIdle);
    wr_take   = load_data && !read_q;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign done     = done_q;
  assign timeout  = timeout_q;
  assign SPI_clk  = sclk_q;
  assign SPI_cs_n = cs_n_q;
  assign SPI_mosi = sr_q[7];

endmodule

// File: tb/tb_tpm_spi_host.sv
// Scoreboard bench for tpm_spi_host: a TPM slave model drives MISO, expected
// MOSI bytes, read bytes and completion records are queued and checked by a monitor.
module tb_tpm_spi_host;

  localparam int CD = 3;
  localparam int MW = 3;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_read = 1'b0;
  logic [5:0]  req_size = '0;
  logic [23:0] req_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        wr_take;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        done;
  logic        timeout;
  logic        SPI_clk;
  logic        SPI_cs_n;
  logic        SPI_mosi;
  logic        SPI_miso = 1'b0;

  tpm_spi_host #(.CLK_DIV(CD), .MAX_WAIT(MW)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_read (req_read),
    .req_size (req_size),
    .req_addr (req_addr),
    .wr_data  (wr_data),
    .wr_take  (wr_take),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .done     (done),
    .timeout  (timeout),
    .SPI_clk  (SPI_clk),
    .SPI_cs_n (SPI_cs_n),
    .SPI_mosi (SPI_mosi),
    .SPI_miso (SPI_miso)
  );

  initial forever #5 clock = ~clock;

  typedef struct {
    logic to;
    int   rises;
    int   takes;
    int   rds;
  } done_t;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_mosi[$];
  logic [7:0]  exp_rd[$];
  done_t       exp_done[$];
  bit          miso_bits[$];
  logic [7:0]  tx_w[64];
  logic [7:0]  tx_r[64];
  int          wr_idx = 0;
  int          mon_rises = 0, mon_takes = 0, mon_rds = 0, mon_bits = 0, done_cnt = 0;
  logic [7:0]  mon_byte = '0;
  logic        prev_sclk = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h expected none", name, act);
  endtask

  // Monitor: pops and compares whenever the DUT presents an observable event.
  initial forever begin
    done_t d;
    @(negedge clock);
    if (!reset_n) begin
      exp_mosi.delete();
      exp_rd.delete();
      exp_done.delete();
      mon_rises = 0; mon_takes = 0; mon_rds = 0; mon_bits = 0;
      prev_sclk = 1'b0;
    end else begin
      if (SPI_clk && !prev_sclk) begin
        mon_rises++;
        mon_byte = {mon_byte[6:0], SPI_mosi};
        mon_bits++;
        if (mon_bits == 8) begin
          mon_bits = 0;
          if (exp_mosi.size() == 0) unexpected("mosi_extra", mon_byte);
          else chk("mosi_byte", mon_byte, exp_mosi.pop_front());
        end
      end
      prev_sclk = SPI_clk;
      if (wr_take) mon_takes++;
      if (rd_valid) begin
        mon_rds++;
        if (exp_rd.size() == 0) unexpected("rd_extra", rd_data);
        else chk("rd_data", rd_data, exp_rd.pop_front());
      end
      if (timeout && !done) unexpected("timeout_without_done", timeout);
      if (done) begin
        if (exp_done.size() == 0) unexpected("done_extra", done);
        else begin
          d = exp_done.pop_front();
          chk("done_timeout", timeout, d.to);
          chk("done_sclk_rises", mon_rises, d.rises);
          chk("done_wr_takes", mon_takes, d.takes);
          chk("done_rd_count", mon_rds, d.rds);
          chk("done_cs_n", SPI_cs_n, 1);
          chk("done_req_ready", req_ready, 1);
          chk("done_mosi_left", exp_mosi.size(), 0);
        end
        mon_rises = 0; mon_takes = 0; mon_rds = 0; mon_bits = 0;
        done_cnt++;
      end
    end
  end

  // Upstream write feeder: next byte presented after each wr_take is consumed.
  initial forever begin
    @(negedge clock);
    if (reset_n && wr_take) begin
      @(posedge clock);
      #1;
      wr_idx++;
      if (wr_idx < 64) wr_data = tx_w[wr_idx];
    end
  end

  // TPM slave: MISO bit k is presented after the k-th falling SCLK edge.
  initial begin
    int   sidx = 0;
    logic pcs = 1'b1;
    logic psclk = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (!SPI_cs_n) begin
        if (pcs) sidx = 0;
        else if (psclk && !SPI_clk) sidx++;
        SPI_miso = (sidx < miso_bits.size()) ? miso_bits[sidx] : 1'b0;
      end else begin
        SPI_miso = 1'b0;
      end
      pcs = SPI_cs_n;
      psclk = SPI_clk;
    end
  end

  task automatic fill_random();
    for (int i = 0; i < 64; i++) begin
      tx_w[i] = 8'($urandom);
      tx_r[i] = 8'($urandom);
    end
  endtask

  // Reference model: derive every expected observation from the request and
  // the number of wait bytes the slave inserts before signalling ready.
  task automatic start_txn(input bit rd, input int sz, input logic [23:0] addr, input int waits);
    bit    to;
    int    nwait, ndata, n;
    done_t d;
    to    = (waits > MW);
    nwait = to ? MW : waits;
    ndata = to ? 0 : sz + 1;
    miso_bits.delete();
    for (int i = 0; i < 32; i++) miso_bits.push_back((i == 31) ? (waits == 0) : 1'($urandom));
    for (int w = 1; w <= nwait; w++)
      for (int j = 0; j < 8; j++) miso_bits.push_back((j == 7) ? (w == waits) : 1'($urandom));
    for (int k = 0; k < ndata; k++)
      for (int j = 7; j >= 0; j--) miso_bits.push_back(rd ? tx_r[k][j] : 1'($urandom));
    exp_mosi.push_back(8'(rd * 128 + sz));
    exp_mosi.push_back(8'((addr / 65536) % 256));
    exp_mosi.push_back(8'((addr / 256) % 256));
    exp_mosi.push_back(8'(addr % 256));
    for (int w = 0; w < nwait; w++) exp_mosi.push_back(8'h00);
    for (int k = 0; k < ndata; k++) begin
      exp_mosi.push_back(rd ? 8'h00 : tx_w[k]);
      if (rd) exp_rd.push_back(tx_r[k]);
    end
    d.to = to;
    d.rises = 8 * (4 + nwait + ndata);
    d.takes = rd ? 0 : ndata;
    d.rds = rd ? ndata : 0;
    exp_done.push_back(d);
    wr_idx = 0;
    wr_data = tx_w[0];
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clock); n++; end
    @(posedge clock);
    #1;
    req_valid = 1'b1;
    req_read = rd;
    req_size = 6'(sz);
    req_addr = addr;
    @(posedge clock);
    #1;
    chk("busy_req_ready", req_ready, 0);
    // Junk request held while busy must be ignored.
    for (int i = 0; i < 10; i++) begin
      req_read = 1'($urandom);
      req_size = 6'($urandom);
      req_addr = 24'($urandom);
      @(posedge clock);
      #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int start, n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < 12000) begin @(negedge clock); n++; end
    if (done_cnt == start) unexpected("done_wait_expired", n);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_cs_n", SPI_cs_n, 1);
    chk("rst_sclk", SPI_clk, 0);
    chk("rst_mosi", SPI_mosi, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_take", wr_take, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    fill_random();
    tx_w[0] = 8'hA5;
    start_txn(1'b0, 0, 24'hD40018, 0);
    wait_done();

    fill_random();
    tx_r[0] = 8'h11; tx_r[1] = 8'h22; tx_r[2] = 8'h33; tx_r[3] = 8'h44;
    start_txn(1'b1, 3, 24'hD40F00, 0);
    wait_done();

    fill_random();
    start_txn(1'b0, 0, 24'hD40024, 2);
    wait_done();

    fill_random();
    start_txn(1'b1, 1, 24'hD40000, 100);
    wait_done();

    fill_random();
    start_txn(1'b1, 63, 24'hD40024, 0);
    wait_done();

    // Reset in the middle of the data phase.
    fill_random();
    start_txn(1'b0, 7, 24'hD40024, 0);
    n = 0;
    while (mon_rises < 44 && n < 5000) begin @(negedge clock); n++; end
    if (mon_rises < 44) unexpected("data_phase_wait_expired", mon_rises);
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    chk("abort_cs_n", SPI_cs_n, 1);
    chk("abort_sclk", SPI_clk, 0);
    chk("abort_req_ready", req_ready, 1);
    chk("abort_done", done, 0);
    reset_n = 1'b1;
    repeat (40) @(posedge clock);
    #1;
    fill_random();
    start_txn(1'b0, 2, 24'hD40F04, 1);
    wait_done();

    for (int t = 0; t < 12; t++) begin
      fill_random();
      start_txn(1'($urandom), ($urandom_range(0, 7) == 0) ? 63 : $urandom_range(0, 15),
                24'($urandom), $urandom_range(0, 5));
      wait_done();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
